// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter that lets N_REQ requesters share one N-bit register.
// Optional macro ARB_LOCK_EN: a locked winner keeps priority at each granting edge.
module reg_write_arbiter #(
  parameter int           N_REQ = 4,
  parameter int           N     = 32,
  parameter logic [N-1:0] RESET = '0,
  parameter int           CW    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*N-1:0]       wdata,
  input  logic [N_REQ-1:0]         lock,
  output logic [N_REQ-1:0]         gnt,
  output logic [N-1:0]             q,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     owner_vld,
  output logic [CW-1:0]            wr_count
);

  localparam int PW = $clog2(N_REQ);

  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic [PW-1:0] win_next;
  logic [PW-1:0] ptr_adv;
  logic          found;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    found = 1'b0;
    win   = '0;
    gnt   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      int idx;
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
    // Reset wins over any request: no grant, no write.
    if (rst) found = 1'b0;
    if (found) gnt[win] = 1'b1;
  end

  // Explicit wrap so non-power-of-two N_REQ never lands on an unused index.
  assign win_next = (win == PW'(N_REQ - 1)) ? '0 : win + 1'b1;

`ifdef ARB_LOCK_EN
  assign ptr_adv = lock[win] ? win : win_next;
`else
  logic unused_lock;
  assign unused_lock = ^lock;
  assign ptr_adv     = win_next;
`endif

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      q         <= RESET;
      owner     <= '0;
      owner_vld <= 1'b0;
      wr_count  <= '0;
      ptr       <= '0;
    end else if (found) begin
      q         <= wdata[int'(win)*N +: N];
      owner     <= win;
      owner_vld <= 1'b1;
      ptr       <= ptr_adv;
      if (wr_count != '1) wr_count <= wr_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: vector table, lock sequence, random phase,
// with a scoreboard queue holding expected register state for each clock edge.
module tb_reg_write_arbiter;

  localparam int           NR    = 4;
  localparam int           N     = 32;
  localparam int           CW    = 2;
  localparam logic [N-1:0] RST_V = 32'hDEAD_BEEF;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req;
  logic [NR*N-1:0]  wdata;
  logic [NR-1:0]    lock;
  logic [NR-1:0]    gnt;
  logic [N-1:0]     q;
  logic [1:0]       owner;
  logic             owner_vld;
  logic [CW-1:0]    wr_count;

  reg_write_arbiter #(.N_REQ(NR), .N(N), .RESET(RST_V), .CW(CW)) dut (
    .clk(clk), .rst(rst), .req(req), .wdata(wdata), .lock(lock), .gnt(gnt),
    .q(q), .owner(owner), .owner_vld(owner_vld), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic [NR-1:0] req;
    logic [NR-1:0] lock;
    logic [N-1:0]  base;
    logic [NR-1:0] exp_gnt;
  } vec_t;

  typedef struct {
    logic [N-1:0]  q;
    logic [1:0]    owner;
    logic          vld;
    logic [CW-1:0] cnt;
  } state_t;

  state_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state
  int            m_ptr = 0;
  logic [N-1:0]  m_q   = RST_V;
  logic [1:0]    m_owner = '0;
  logic          m_vld = 1'b0;
  logic [CW-1:0] m_cnt = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_winner(input logic [NR-1:0] r);
    for (int k = 0; k < NR; k++)
      if (r[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
    return -1;
  endfunction

  // One cycle: drive, check combinational grant, update model, check state after the edge.
  task automatic step(input logic r, input logic [NR-1:0] rq, input logic [NR-1:0] lk,
                      input logic [N-1:0] base, input logic use_tbl, input logic [NR-1:0] tgnt);
    int w;
    logic [NR-1:0] mg;
    state_t s, got;
    @(negedge clk);
    rst  = r;
    req  = rq;
    lock = lk;
    for (int i = 0; i < NR; i++) wdata[i*N +: N] = base + N'(i);
    #1;
    w  = r ? -1 : m_winner(rq);
    mg = '0;
    if (w >= 0) mg[w] = 1'b1;
    check("gnt", 64'(gnt), 64'(use_tbl ? tgnt : mg));
    if (r) begin
      m_q = RST_V; m_owner = '0; m_vld = 1'b0; m_cnt = '0; m_ptr = 0;
    end else if (w >= 0) begin
      m_q     = base + N'(w);
      m_owner = 2'(w);
      m_vld   = 1'b1;
      if (m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
`ifdef ARB_LOCK_EN
      if (lk[w]) m_ptr = w;
      else m_ptr = (w + 1) % NR;
`else
      m_ptr = (w + 1) % NR;
`endif
    end
    s.q = m_q; s.owner = m_owner; s.vld = m_vld; s.cnt = m_cnt;
    exp_q.push_back(s);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 64'(1), 64'(0));
    end else begin
      got = exp_q.pop_front();
      check("q", 64'(q), 64'(got.q));
      check("owner", 64'(owner), 64'(got.owner));
      check("owner_vld", 64'(owner_vld), 64'(got.vld));
      check("wr_count", 64'(wr_count), 64'(got.cnt));
    end
  endtask

  vec_t tbl[$];

  initial begin
    rst = 1'b1; req = '0; lock = '0; wdata = '0;

    // Reset, rotation, wrap/skip, idle, single requester, reset mid-op, saturation.
    tbl.push_back('{1'b1, 4'b1111, 4'b0000, 32'h00, 4'b0000});
    tbl.push_back('{1'b1, 4'b1111, 4'b0000, 32'h00, 4'b0000});
    for (int i = 0; i < 8; i++)
      tbl.push_back('{1'b0, 4'b1111, 4'b0000, 32'h10, 4'(1 << (i % 4))});
    tbl.push_back('{1'b0, 4'b0100, 4'b0000, 32'h30, 4'b0100});
    tbl.push_back('{1'b0, 4'b0101, 4'b0000, 32'h40, 4'b0001});
    tbl.push_back('{1'b0, 4'b0101, 4'b0000, 32'h50, 4'b0100});
    tbl.push_back('{1'b0, 4'b0000, 4'b0000, 32'h60, 4'b0000});
    tbl.push_back('{1'b0, 4'b0010, 4'b0000, 32'h70, 4'b0010});
    tbl.push_back('{1'b0, 4'b0010, 4'b0000, 32'h74, 4'b0010});
    tbl.push_back('{1'b0, 4'b0010, 4'b0000, 32'h78, 4'b0010});
    tbl.push_back('{1'b0, 4'b0100, 4'b0000, 32'h80, 4'b0100});
    tbl.push_back('{1'b1, 4'b1000, 4'b0000, 32'h90, 4'b0000});
    tbl.push_back('{1'b0, 4'b1010, 4'b0000, 32'hA0, 4'b0010});
    tbl.push_back('{1'b0, 4'b1111, 4'b0000, 32'hB0, 4'b0100});
    tbl.push_back('{1'b0, 4'b1111, 4'b0000, 32'hC0, 4'b1000});
    tbl.push_back('{1'b0, 4'b0001, 4'b0000, 32'hD0, 4'b0001});
    tbl.push_back('{1'b0, 4'b0001, 4'b0000, 32'hD4, 4'b0001});
    tbl.push_back('{1'b0, 4'b0001, 4'b0000, 32'hD8, 4'b0001});

    foreach (tbl[i])
      step(tbl[i].rst, tbl[i].req, tbl[i].lock, tbl[i].base, 1'b1, tbl[i].exp_gnt);

    // Lock burst on requester 1, then release; model decides per build.
    step(1'b1, 4'b0000, 4'b0000, 32'h00, 1'b0, '0);
    step(1'b0, 4'b0010, 4'b0000, 32'h100, 1'b0, '0);
    for (int i = 0; i < 4; i++)
      step(1'b0, 4'b1111, 4'b0010, 32'h110 + 32'(i * 16), 1'b0, '0);
    for (int i = 0; i < 3; i++)
      step(1'b0, 4'b1111, 4'b0000, 32'h200 + 32'(i * 16), 1'b0, '0);

    // Random traffic with occasional reset.
    for (int i = 0; i < 40; i++)
      step(($urandom_range(0, 15) == 0), 4'($urandom), 4'($urandom), $urandom, 1'b0, '0);

    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
